// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Tracks the destination registers of instructions in flight through the
//   E/M/W stages and resolves operand forwarding and load-use style stalls
//   for the D stage.
//
//   Handshake: there is no valid/ready pair. An issue is accepted at a rising
//   edge only when issue_valid=1, issue_addr!=0, stall=0 and flush=0; in every
//   other case a bubble enters the E slot.
//
// Ports
//   clk, reset    rising-edge clock, synchronous active-high reset
//   issue_valid   D-stage instruction writes a register
//   issue_addr    its destination register
//   issue_tnew    cycles after entering E until its result is valid
//   flush         invalidate all tracked entries at the next edge
//   rd_addr       read register per port (port p at [5p+4:5p])
//   rd_tuse       cycles until port p's value is consumed
//   rd_data       register-file read data per port
//   stage_data    result data held in each tracked stage (entry 0 = E)
//   fwd_data      forwarded operand per port
//   fwd_hit       port p is taking data from stage_data
//   stall         D stage must hold
//   stall_cnt     number of stall cycles seen (wraps)
module fwd_scoreboard #(
    parameter int NPORT = 2,
    parameter int DEPTH = 3,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_addr,
    input  logic [1:0]             issue_tnew,
    input  logic                   flush,
    input  logic [NPORT*5-1:0]     rd_addr,
    input  logic [NPORT*2-1:0]     rd_tuse,
    input  logic [NPORT*WIDTH-1:0] rd_data,
    input  logic [DEPTH*WIDTH-1:0] stage_data,
    output logic [NPORT*WIDTH-1:0] fwd_data,
    output logic [NPORT-1:0]       fwd_hit,
    output logic                   stall,
    output logic [31:0]            stall_cnt
);

    logic [DEPTH-1:0] ent_valid;
    logic [4:0]       ent_addr [DEPTH];
    logic [1:0]       ent_tnew [DEPTH];
    logic             issue_accept;

    // A stalled D stage never enters E, so stall forces a bubble. stall is
    // computed from the entries only, so this creates no loop.
    assign issue_accept = issue_valid && (issue_addr != 5'd0) && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            ent_valid <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_addr[i]  <= ent_addr[i-1];
                ent_tnew[i]  <= (ent_tnew[i-1] == 2'd0) ? 2'd0 : ent_tnew[i-1] - 2'd1;
            end
            ent_valid[0] <= issue_accept;
            ent_addr[0]  <= issue_addr;
            ent_tnew[0]  <= issue_tnew;
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    // Per port, only the youngest matching entry counts: if it is not ready
    // yet the register-file value is used (and possibly a stall raised),
    // never an older, stale producer of the same register.
    always_comb begin
        logic found;
        fwd_data = rd_data;
        fwd_hit  = '0;
        stall    = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            found = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && ent_valid[i] && (rd_addr[p*5 +: 5] != 5'd0) &&
                    (ent_addr[i] == rd_addr[p*5 +: 5])) begin
                    found = 1'b1;
                    if (ent_tnew[i] == 2'd0) begin
                        fwd_data[p*WIDTH +: WIDTH] = stage_data[i*WIDTH +: WIDTH];
                        fwd_hit[p] = 1'b1;
                    end
                    if (ent_tnew[i] > rd_tuse[p*2 +: 2]) begin
                        stall = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

    localparam int NPORT = 2;
    localparam int DEPTH = 3;
    localparam int WIDTH = 32;

    localparam logic [31:0] RD0 = 32'h1111_0000;
    localparam logic [31:0] RD1 = 32'h2222_0000;
    localparam logic [31:0] SD0 = 32'h0000_A0A0;
    localparam logic [31:0] SD1 = 32'h0000_B0B0;
    localparam logic [31:0] SD2 = 32'h0000_C0C0;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   issue_valid;
    logic [4:0]             issue_addr;
    logic [1:0]             issue_tnew;
    logic                   flush;
    logic [NPORT*5-1:0]     rd_addr;
    logic [NPORT*2-1:0]     rd_tuse;
    logic [NPORT*WIDTH-1:0] rd_data;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic [NPORT*WIDTH-1:0] fwd_data;
    logic [NPORT-1:0]       fwd_hit;
    logic                   stall;
    logic [31:0]            stall_cnt;

    int vecs = 0;
    int errs = 0;

    fwd_scoreboard #(.NPORT(NPORT), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_tnew  (issue_tnew),
        .flush       (flush),
        .rd_addr     (rd_addr),
        .rd_tuse     (rd_tuse),
        .rd_data     (rd_data),
        .stage_data  (stage_data),
        .fwd_data    (fwd_data),
        .fwd_hit     (fwd_hit),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // inputs change 2 time units after the active edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [4:0] a, input logic [1:0] t);
        issue_valid = 1'b1;
        issue_addr  = a;
        issue_tnew  = t;
        tick();
        issue_valid = 1'b0;
        issue_addr  = 5'd0;
        issue_tnew  = 2'd0;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a, input logic [1:0] t);
        rd_addr[p*5 +: 5] = a;
        rd_tuse[p*2 +: 2] = t;
    endtask

    task automatic drain();
        rd_addr = '0;
        rd_tuse = '0;
        repeat (DEPTH) tick();
    endtask

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_addr  = 5'd0;
        issue_tnew  = 2'd0;
        flush       = 1'b0;
        rd_addr     = '0;
        rd_tuse     = '0;
        rd_data     = {RD1, RD0};
        stage_data  = {SD2, SD1, SD0};
        tick();
        tick();
        reset = 1'b0;

        // reset state
        set_rd(0, 5'd8, 2'd0);
        set_rd(1, 5'd9, 2'd0);
        settle();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_hit", {30'd0, fwd_hit}, 32'd0);
        check("rst_fwd0", fwd_data[31:0], RD0);
        check("rst_fwd1", fwd_data[63:32], RD1);
        check("rst_cnt", stall_cnt, 32'd0);

        // issue $8 tnew=0, forwarded from E next cycle
        rd_addr = '0;
        issue(5'd8, 2'd0);
        stage_data[31:0] = 32'h0000_1234;
        set_rd(0, 5'd8, 2'd0);
        set_rd(1, 5'd3, 2'd0);
        settle();
        check("e_fwd0", fwd_data[31:0], 32'h0000_1234);
        check("e_hit", {30'd0, fwd_hit}, 32'd1);
        check("e_stall", {31'd0, stall}, 32'd0);
        check("e_fwd1", fwd_data[63:32], RD1);
        stage_data = {SD2, SD1, SD0};
        drain();

        // issue $9 tnew=2, consumed immediately: two stall cycles
        issue(5'd9, 2'd2);
        set_rd(0, 5'd9, 2'd0);
        settle();
        check("s2_stall_e", {31'd0, stall}, 32'd1);
        check("s2_hit_e", {30'd0, fwd_hit}, 32'd0);
        check("s2_fwd_e", fwd_data[31:0], RD0);
        tick();
        check("s2_stall_m", {31'd0, stall}, 32'd1);
        check("s2_cnt_m", stall_cnt, 32'd1);
        tick();
        check("s2_stall_w", {31'd0, stall}, 32'd0);
        check("s2_hit_w", {30'd0, fwd_hit}, 32'd1);
        check("s2_fwd_w", fwd_data[31:0], SD2);
        check("s2_cnt_w", stall_cnt, 32'd2);
        drain();

        // $5 issued twice: the younger (E) producer wins
        issue(5'd5, 2'd0);
        issue(5'd5, 2'd0);
        set_rd(0, 5'd5, 2'd0);
        set_rd(1, 5'd5, 2'd3);
        settle();
        check("dup_fwd0", fwd_data[31:0], SD0);
        check("dup_fwd1", fwd_data[63:32], SD0);
        check("dup_hit", {30'd0, fwd_hit}, 32'd3);
        drain();

        // younger not ready, older ready: use register file, never the older
        issue(5'd4, 2'd0);
        issue(5'd4, 2'd2);
        set_rd(1, 5'd4, 2'd2);
        settle();
        check("yng_stall_eq", {31'd0, stall}, 32'd0);
        check("yng_hit", {30'd0, fwd_hit}, 32'd0);
        check("yng_fwd1", fwd_data[63:32], RD1);
        set_rd(1, 5'd4, 2'd1);
        settle();
        check("yng_stall_gt", {31'd0, stall}, 32'd1);
        drain();

        // register 0 is never tracked
        issue(5'd0, 2'd3);
        set_rd(0, 5'd0, 2'd0);
        settle();
        check("r0_fwd0", fwd_data[31:0], RD0);
        check("r0_hit", {30'd0, fwd_hit}, 32'd0);
        check("r0_stall", {31'd0, stall}, 32'd0);
        check("r0_cnt", stall_cnt, 32'd2);
        drain();

        // flush during a stall: entries cleared, counter holds
        issue(5'd7, 2'd3);
        set_rd(0, 5'd7, 2'd0);
        settle();
        check("fl_stall_a", {31'd0, stall}, 32'd1);
        tick();
        check("fl_cnt_a", stall_cnt, 32'd3);
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_addr  = 5'd6;
        issue_tnew  = 2'd0;
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        set_rd(1, 5'd6, 2'd0);
        settle();
        check("fl_stall", {31'd0, stall}, 32'd0);
        check("fl_hit", {30'd0, fwd_hit}, 32'd0);
        check("fl_cnt", stall_cnt, 32'd3);
        drain();

        // counter wrap, then reset during a stall
        issue(5'd7, 2'd3);
        set_rd(0, 5'd7, 2'd0);
        settle();
        check("wr_stall", {31'd0, stall}, 32'd1);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        tick();
        check("wr_cnt", stall_cnt, 32'd0);
        check("wr_stall_m", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("rs_stall", {31'd0, stall}, 32'd0);
        check("rs_cnt", stall_cnt, 32'd0);
        check("rs_fwd0", fwd_data[31:0], RD0);
        check("rs_hit", {30'd0, fwd_hit}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- NPORT, 2, number of register read ports forwarded.
- DEPTH, 3, number of in-flight pipeline stages tracked (entry 0 = E, 1 = M, 2 = W).
- WIDTH, 32, data width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below (name, direction, width, meaning).
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- issue_valid, in, 1, D-stage instruction writes a register.
- issue_addr, in, 5, destination register of the D-stage instruction.
- issue_tnew, in, 2, cycles after entering E until its result is valid.
- flush, in, 1, invalidate all tracked entries at the next edge.
- rd_addr, in, NPORT*5, read register per port (port p at bits [5p+4:5p]).
- rd_tuse, in, NPORT*2, cycles until port p's value is consumed.
- rd_data, in, NPORT*WIDTH, GRF read data per port (GRF is write-through).
- stage_data, in, DEPTH*WIDTH, result data held in each tracked stage.
- fwd_data, out, NPORT*WIDTH, forwarded operand per port.
- fwd_hit, out, NPORT, port p is taking data from stage_data.
- stall, out, 1, D stage must hold.
- stall_cnt, out, 32, count of stall cycles.

Function
REQ-003 The block SHALL hold DEPTH entries {valid, addr[4:0], tnew[1:0]}.
REQ-004 The block SHALL update the entries on every rising edge when reset=0 and flush=0, as follows:
- entry i SHALL take entry i-1 for i>=1, with tnew decremented and saturating at 0;
- entry DEPTH-1 SHALL be discarded.
REQ-005 Entry 0 SHALL load {1, issue_addr, issue_tnew} when issue_valid=1, issue_addr!=0 and stall=0.
REQ-006 In every other case entry 0 SHALL load a bubble (valid=0); in particular, stall=1 in the same cycle always inserts a bubble.
REQ-007 Register 0 SHALL never be tracked or matched.
REQ-008 Per port p, the block SHALL combinationally select the lowest-index valid entry i with addr==rd_addr[p] and rd_addr[p]!=0; younger entries take priority.
REQ-009 If the selected entry has tnew==0, the block SHALL drive fwd_data[p]=stage_data[i] and fwd_hit[p]=1.
REQ-010 Otherwise the block SHALL drive fwd_data[p]=rd_data[p] and fwd_hit[p]=0; older matching entries SHALL NOT be used.
REQ-011 stall SHALL be 1 iff some port has a selected entry with tnew > rd_tuse[p].
REQ-012 Lookup SHALL be zero-latency (combinational from inputs and current entries); entry state SHALL update with one-cycle latency.
REQ-013 stall_cnt SHALL increment by 1 on each edge where stall=1 and flush=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-014 When flush=1, all entries SHALL become invalid at the next edge, regardless of issue_valid or stall; stall_cnt SHALL hold.
REQ-015 stall SHALL depend only on current entries, never on issue_* inputs; there is no combinational loop from issue to stall.

Reset
REQ-016 When reset=1 at an edge, all entry valid bits SHALL clear to 0 and stall_cnt SHALL clear to 0; reset has priority over flush and issue.
REQ-017 After reset, outputs SHALL be stall=0, fwd_hit=0 and fwd_data=rd_data.
REQ-018 Reset asserted mid-stall SHALL drop stall in the cycle after the reset edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Issue $8, tnew=0; next cycle rd_addr0=8, stage_data[0]=0x1234 -> fwd_data0=0x1234, fwd_hit0=1, stall=0.
- Issue $9, tnew=2; next cycle rd_addr0=9, tuse=0 -> stall=1 for 2 cycles while the entry advances to M; then fwd from stage_data[2]; stall_cnt=2.
- Issue $5 (tnew=0) twice consecutively; read $5 -> entry 0's stage_data selected, not entry 1's.
- Read $0 with a valid entry addr=0 attempted -> no tracking, fwd_data0=rd_data0, stall=0.
- Stall active, then flush=1 -> all entries invalid next cycle, stall=0, stall_cnt unchanged.
- stall_cnt preloaded to 0xFFFFFFFF via 2^32-1 stall cycles (or a force) plus one more stall cycle -> 0; reset during stall -> stall=0, stall_cnt=0.
